// File: rtl/img_pkg.sv
// img_pkg: image geometry constants and writer FSM state type shared by the result writer.
package img_pkg;
  localparam int SIZE_ROW        = 352;
  localparam int NUM_ROWS        = 288;
  localparam int WORDS_PER_IMAGE = SIZE_ROW * NUM_ROWS / 4;
  localparam int ADDR_W          = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} writer_state_t;
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: gathers four 8-bit pixels into one 32-bit word.
// RESULT_WRITER_BIG_ENDIAN_EN puts the first pixel in the top byte instead of the bottom.
module pixel_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  pix_i,
  output logic [31:0] word_o,
  output logic        group_done_o
);
  logic [1:0]  cnt_q, cnt_d, lane;
  logic [31:0] pack_q, pack_d;
  logic [4:0]  sh;
`ifdef RESULT_WRITER_BIG_ENDIAN_EN
  assign lane = 2'd3 - cnt_q;
`else
  assign lane = cnt_q;
`endif
  assign sh = {lane, 3'b000};
  // word_o already carries the pixel being accepted, so the fourth pixel needs no extra cycle
  assign word_o       = (pack_q & ~(32'hFF << sh)) | ({24'h0, pix_i} << sh);
  assign group_done_o = accept_i && cnt_q == 2'd3;
  always_comb begin
    cnt_d  = clear_i ? 2'd0 : accept_i ? cnt_q + 2'd1 : cnt_q;
    pack_d = clear_i ? 32'h0 : accept_i ? word_o : pack_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      pack_q <= 32'h0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end
endmodule

// File: rtl/result_writer.sv
// result_writer: packs a raster of result pixels into 32-bit words and writes them to memory.
// RESULT_WRITER_BIG_ENDIAN_EN (see pixel_packer) selects MSB-first byte order.
module result_writer #(
  parameter int SIZE_ROW   = img_pkg::SIZE_ROW,
  parameter int NUM_ROWS   = img_pkg::NUM_ROWS,
  parameter int WRITE_BASE = 25344
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        pix_ready,
  output logic        o_en,
  output logic        o_we,
  output logic [15:0] o_addr,
  output logic [31:0] o_word,
  output logic        o_finish
);
  import img_pkg::*;
  localparam int WORDS = SIZE_ROW * NUM_ROWS / 4;
  localparam int WW    = $clog2(WORDS + 1);
  generate
    if (SIZE_ROW % 4 != 0) begin : g_size_chk
      $error("result_writer: SIZE_ROW must be a multiple of 4");
    end
  endgenerate
  writer_state_t     state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, packed_word;
  logic              accept, clear, group_done, all_written;
  assign all_written = word_q == WW'(WORDS);
  assign accept      = pix_valid && pix_ready;
  assign clear       = state_q == IDLE && start;
  pixel_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear),
    .accept_i     (accept),
    .pix_i        (pix_in),
    .word_o       (packed_word),
    .group_done_o (group_done)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // leave RUN on the cycle the last word is on the bus
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (all_written ? DONE : RUN) : IDLE;
  end
  always_comb begin
    pix_ready = state_q == RUN && !all_written;
    o_finish  = state_q == DONE;
  end
  always_comb begin
    word_d = clear ? '0 : group_done ? word_q + 1'b1 : word_q;
    en_d   = group_done;
    addr_d = group_done ? ADDR_W'(WRITE_BASE) + ADDR_W'(word_q) : addr_q;
    data_d = group_done ? packed_word : data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= 32'h0;
    end else begin
      word_q <= word_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign o_en   = en_q;
  assign o_we   = en_q;
  assign o_addr = addr_q;
  assign o_word = data_q;
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: directed checks of result_writer on an 8x2 image (four words).
module tb_result_writer;
  localparam logic [15:0] BASE = 16'd25344;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pix_in = 8'h0;
  logic        pix_ready, o_en, o_we, o_finish;
  logic [15:0] o_addr;
  logic [31:0] o_word;
  int tests = 0, fails = 0;
  int ncyc = 0, wcyc = 0, fcyc = 0, fin_n = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];

  result_writer #(.SIZE_ROW(8), .NUM_ROWS(2), .WRITE_BASE(25344)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .o_en(o_en), .o_we(o_we), .o_addr(o_addr), .o_word(o_word),
    .o_finish(o_finish)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    if (o_we) begin
      wa.push_back(o_addr);
      wd.push_back(o_word);
      wcyc = ncyc;
    end
    if (o_finish) begin
      fin_n++;
      fcyc = ncyc;
    end
  end

  function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
`ifdef RESULT_WRITER_BIG_ENDIAN_EN
    return {a, b, c, d};
`else
    return {d, c, b, a};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = 8'h0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    wa.delete(); wd.delete(); fin_n = 0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] p, input int gap);
    pix_valid = 1'b1; pix_in = p;
    tick(1);
    pix_valid = 1'b0;
    tick(gap);
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({pix_ready, o_en, o_we, o_finish} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {pix_ready, o_en, o_we, o_finish});
    end
    do_reset;
    do_start;
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 0);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({o_we, o_en, o_addr, o_word, pix_ready} !== 51'b0) begin
      fails++; $display("FAIL async_reset: got we=%b addr=%h word=%h rdy=%b expected all 0", o_we, o_addr, o_word, pix_ready);
    end
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset;
    do_start;
    tests++;
    if (pix_ready !== 1'b1) begin
      fails++; $display("FAIL run_ready: got %b expected 1", pix_ready);
    end
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    tests++;
    if ({o_en, o_we, o_addr, o_word} !== {2'b11, BASE, pk(8'h01, 8'h02, 8'h03, 8'h04)}) begin
      fails++; $display("FAIL basic_write: got en=%b we=%b addr=%h word=%h expected 1 1 %h %h", o_en, o_we, o_addr, o_word, BASE, pk(8'h01, 8'h02, 8'h03, 8'h04));
    end
    tick(1);
    tests++;
    if ({o_we, o_addr, o_word} !== {1'b0, BASE, pk(8'h01, 8'h02, 8'h03, 8'h04)}) begin
      fails++; $display("FAIL basic_hold: got we=%b addr=%h word=%h", o_we, o_addr, o_word);
    end
  endtask

  task automatic test_gaps;
    do_reset;
    do_start;
    send(8'h01, 3); send(8'h02, 3); send(8'h03, 3);
    tests++;
    if (wa.size() !== 0) begin
      fails++; $display("FAIL gap_early: got %0d writes expected 0", wa.size());
    end
    send(8'h04, 5);
    tests++;
    if (wa.size() !== 1 || wa[0] !== BASE || wd[0] !== pk(8'h01, 8'h02, 8'h03, 8'h04)) begin
      fails++; $display("FAIL gap_write: got %0d writes first %h/%h expected 1 %h/%h", wa.size(), (wa.size() > 0) ? wa[0] : 16'h0, (wd.size() > 0) ? wd[0] : 32'h0, BASE, pk(8'h01, 8'h02, 8'h03, 8'h04));
    end
  endtask

  task automatic test_full;
    logic [7:0] p;
    do_reset;
    do_start;
    for (int i = 0; i < 16; i++) begin
      p = 8'(i + 1);
      send(p, i % 3);
    end
    pix_valid = 1'b1; pix_in = 8'hEE;
    tick(6);
    pix_valid = 1'b0;
    tick(2);
    tests++;
    if (wa.size() !== 4) begin
      fails++; $display("FAIL full_count: got %0d writes expected 4", wa.size());
    end
    for (int j = 0; j < 4 && j < wa.size(); j++) begin
      p = 8'(4 * j);
      tests++;
      if (wa[j] !== BASE + 16'(j) || wd[j] !== pk(p + 8'd1, p + 8'd2, p + 8'd3, p + 8'd4)) begin
        fails++; $display("FAIL full_word%0d: got %h/%h expected %h/%h", j, wa[j], wd[j], BASE + 16'(j), pk(p + 8'd1, p + 8'd2, p + 8'd3, p + 8'd4));
      end
    end
    tests++;
    if (fin_n !== 1 || fcyc !== wcyc + 1) begin
      fails++; $display("FAIL finish: got %0d pulses at cycle %0d, last write %0d expected 1 at write+1", fin_n, fcyc, wcyc);
    end
    tests++;
    if (pix_ready !== 1'b0 || o_finish !== 1'b0) begin
      fails++; $display("FAIL back_idle: got rdy=%b fin=%b expected 0 0", pix_ready, o_finish);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    do_start;
    send(8'h11, 0); send(8'h22, 0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    tests++;
    if (wa.size() !== 0) begin
      fails++; $display("FAIL mid_reset_nowrite: got %0d writes expected 0", wa.size());
    end
    do_start;
    for (int i = 0; i < 4; i++) send(8'hAA, 0);
    tick(2);
    tests++;
    if (wa.size() !== 1 || wa[0] !== BASE || wd[0] !== 32'hAAAAAAAA) begin
      fails++; $display("FAIL mid_reset_write: got %0d writes first %h/%h expected 1 %h/aaaaaaaa", wa.size(), (wa.size() > 0) ? wa[0] : 16'h0, (wd.size() > 0) ? wd[0] : 32'h0, BASE);
    end
  endtask

  task automatic test_start_in_run;
    do_reset;
    do_start;
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 0);
    send(8'h50, 0);
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'h51;
    tick(1);
    start = 1'b0; pix_valid = 1'b0;
    tick(1);
    send(8'h52, 0); send(8'h53, 0);
    tests++;
    if ({o_we, o_addr, o_word} !== {1'b1, BASE + 16'd2, pk(8'h50, 8'h51, 8'h52, 8'h53)}) begin
      fails++; $display("FAIL start_in_run: got we=%b addr=%h word=%h expected 1 %h %h", o_we, o_addr, o_word, BASE + 16'd2, pk(8'h50, 8'h51, 8'h52, 8'h53));
    end
  endtask

  task automatic test_idle_ignore;
    do_reset;
    pix_valid = 1'b1; pix_in = 8'hFF;
    tick(3);
    tests++;
    if (pix_ready !== 1'b0 || wa.size() !== 0) begin
      fails++; $display("FAIL idle_ignore: got rdy=%b writes=%0d expected 0 0", pix_ready, wa.size());
    end
    pix_valid = 1'b0;
    do_start;
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
    tests++;
    if ({o_we, o_addr, o_word} !== {1'b1, BASE, pk(8'h05, 8'h06, 8'h07, 8'h08)}) begin
      fails++; $display("FAIL idle_not_packed: got we=%b addr=%h word=%h expected 1 %h %h", o_we, o_addr, o_word, BASE, pk(8'h05, 8'h06, 8'h07, 8'h08));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_full;
    test_reset_mid;
    test_start_in_run;
    test_idle_ignore;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
